// File: rtl/pipe_stage_ctrl.sv
// Valid/allowin sequencer for the 5-stage IF/ID/EXE/MEM/WB pipeline, including
// the cancel tracking for a fetch still in flight when a redirect happens.
module pipe_stage_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             fs_ready_go,
   input  logic             ds_br_taken,
   input  logic             load_hazard,
   input  logic             es_ready_go,
   input  logic             ms_ready_go,
   input  logic             ws_flush,
   output logic [4:0]       stage_valid,
   output logic [4:0]       stage_load,
   output logic             pc_update,
   output logic             redirect_pend,
   output logic [CNT_W-1:0] stall_cnt
);

   logic fs_valid, ds_valid, es_valid, ms_valid, ws_valid;
   logic fs_cancel;
   logic to_fs_valid;

   logic ds_ready_go;
   logic fs_allowin, ds_allowin, es_allowin, ms_allowin;
   logic br_fire, flush_now;
   logic fs_to_ds_valid, ds_to_es_valid, es_to_ms_valid, ms_to_ws_valid;

   assign ds_ready_go = !load_hazard;

   // WB always accepts, so MEM only waits on its own ready_go.
   assign ms_allowin = !ms_valid || ms_ready_go;
   assign es_allowin = !es_valid || (es_ready_go && ms_allowin);
   assign ds_allowin = !ds_valid || (ds_ready_go && es_allowin);

   assign br_fire   = ds_valid && ds_br_taken && !load_hazard && es_allowin;
   assign flush_now = ws_valid && ws_flush;

   // A returning fetch may also be discarded, so IF frees up on cancel or redirect
   // even when ID is blocked.
   assign fs_allowin = !fs_valid || (fs_ready_go && (ds_allowin || fs_cancel || br_fire));

   assign fs_to_ds_valid = fs_valid && fs_ready_go && !fs_cancel && !br_fire;
   assign ds_to_es_valid = ds_valid && ds_ready_go;
   assign es_to_ms_valid = es_valid && es_ready_go;
   assign ms_to_ws_valid = ms_valid && ms_ready_go;

   assign stage_valid = {ws_valid, ms_valid, es_valid, ds_valid, fs_valid};
   assign stage_load  = {ms_to_ws_valid,
                         es_to_ms_valid && ms_allowin,
                         ds_to_es_valid && es_allowin,
                         fs_to_ds_valid && ds_allowin,
                         to_fs_valid    && fs_allowin};
   assign pc_update     = to_fs_valid && fs_allowin;
   assign redirect_pend = fs_cancel;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fs_valid    <= 1'b0;
         ds_valid    <= 1'b0;
         es_valid    <= 1'b0;
         ms_valid    <= 1'b0;
         ws_valid    <= 1'b0;
         fs_cancel   <= 1'b0;
         to_fs_valid <= 1'b0;
         stall_cnt   <= '0;
      end else begin
         to_fs_valid <= 1'b1;

         if (ds_valid && load_hazard)
            stall_cnt <= stall_cnt + CNT_W'(1);

         // Only one fetch can be outstanding, so a single cancel bit suffices.
         if (fs_valid && fs_ready_go)
            fs_cancel <= 1'b0;
         else if (fs_valid && (flush_now || br_fire))
            fs_cancel <= 1'b1;

         if (flush_now) begin
            ds_valid <= 1'b0;
            es_valid <= 1'b0;
            ms_valid <= 1'b0;
            ws_valid <= 1'b0;
            if (!(fs_valid && !fs_ready_go))
               fs_valid <= to_fs_valid;
         end else begin
            if (fs_allowin) fs_valid <= to_fs_valid;
            if (ds_allowin) ds_valid <= fs_to_ds_valid;
            if (es_allowin) es_valid <= ds_to_es_valid;
            if (ms_allowin) ms_valid <= es_to_ms_valid;
            ws_valid <= ms_to_ws_valid;
         end
      end
   end

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Directed bench for pipe_stage_ctrl: fill, load-use stall, EXE backpressure,
// branch with pending fetch, WB flush, flush+branch and async reset.
module tb_pipe_stage_ctrl;

   localparam int CNT_W = 32;

   logic             clk;
   logic             resetn;
   logic             fs_ready_go;
   logic             ds_br_taken;
   logic             load_hazard;
   logic             es_ready_go;
   logic             ms_ready_go;
   logic             ws_flush;
   logic [4:0]       stage_valid;
   logic [4:0]       stage_load;
   logic             pc_update;
   logic             redirect_pend;
   logic [CNT_W-1:0] stall_cnt;

   int n_chk = 0;
   int n_bad = 0;

   pipe_stage_ctrl #(.CNT_W(CNT_W)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .fs_ready_go   (fs_ready_go),
      .ds_br_taken   (ds_br_taken),
      .load_hazard   (load_hazard),
      .es_ready_go   (es_ready_go),
      .ms_ready_go   (ms_ready_go),
      .ws_flush      (ws_flush),
      .stage_valid   (stage_valid),
      .stage_load    (stage_load),
      .pc_update     (pc_update),
      .redirect_pend (redirect_pend),
      .stall_cnt     (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance one clock edge, leaving time to change inputs before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic drive(input logic f, input logic br, input logic lh,
                        input logic e, input logic m, input logic fl);
      fs_ready_go = f;
      ds_br_taken = br;
      load_hazard = lh;
      es_ready_go = e;
      ms_ready_go = m;
      ws_flush    = fl;
   endtask

   initial begin
      resetn = 1'b0;
      drive(1, 0, 0, 1, 1, 0);
      #2;
      chk("rst_valid", 32'(stage_valid), 32'h0);
      chk("rst_load",  32'(stage_load),  32'h0);
      chk("rst_pc",    32'(pc_update),   32'h0);
      chk("rst_pend",  32'(redirect_pend), 32'h0);
      chk("rst_cnt",   stall_cnt, 32'h0);

      @(posedge clk);
      #1 resetn = 1'b1;

      // Steady fill with everything ready.
      step(); #1;
      chk("fill_pc1",    32'(pc_update),   32'h1);
      chk("fill_valid1", 32'(stage_valid), 32'h00);
      chk("fill_load1",  32'(stage_load),  32'h01);
      step(); #1;
      chk("fill_valid2", 32'(stage_valid), 32'h01);
      chk("fill_load2",  32'(stage_load),  32'h03);
      steps(4); #1;
      chk("fill_full",   32'(stage_valid), 32'h1f);
      chk("fill_loadall", 32'(stage_load), 32'h1f);

      // One-cycle load-use hazard.
      drive(1, 0, 1, 1, 1, 0); #1;
      chk("lu_load", 32'(stage_load), 32'h18);
      chk("lu_pc",   32'(pc_update),  32'h0);
      step();
      drive(1, 0, 0, 1, 1, 0); #1;
      chk("lu_bubble", 32'(stage_valid), 32'h1b);
      chk("lu_cnt",    stall_cnt, 32'h1);
      chk("lu_load2",  32'(stage_load), 32'h17);
      step(); #1;
      chk("lu_valid2", 32'(stage_valid), 32'h17);
      steps(2); #1;
      chk("lu_refull", 32'(stage_valid), 32'h1f);

      // EXE busy for three cycles.
      drive(1, 0, 0, 0, 1, 0); #1;
      chk("ex_load0", 32'(stage_load), 32'h10);
      chk("ex_pc0",   32'(pc_update),  32'h0);
      step(); #1;
      chk("ex_valid1", 32'(stage_valid), 32'h17);
      chk("ex_pc1",    32'(pc_update),   32'h0);
      chk("ex_load1",  32'(stage_load),  32'h00);
      step(); #1;
      chk("ex_valid2", 32'(stage_valid), 32'h07);
      chk("ex_pc2",    32'(pc_update),   32'h0);
      step();
      drive(1, 0, 0, 1, 1, 0); #1;
      chk("ex_valid3", 32'(stage_valid), 32'h07);
      chk("ex_resume_pc",   32'(pc_update),  32'h1);
      chk("ex_resume_load", 32'(stage_load), 32'h0f);
      steps(2); #1;
      chk("ex_refull", 32'(stage_valid), 32'h1f);

      // Taken branch in ID while the fetch is still pending.
      drive(0, 1, 0, 1, 1, 0); #1;
      chk("br_load", 32'(stage_load), 32'h1c);
      chk("br_pc",   32'(pc_update),  32'h0);
      step();
      drive(0, 0, 0, 1, 1, 0); #1;
      chk("br_pend1",  32'(redirect_pend), 32'h1);
      chk("br_valid1", 32'(stage_valid),   32'h1d);
      chk("br_pc1",    32'(pc_update),     32'h0);
      step();
      drive(1, 0, 0, 1, 1, 0); #1;
      chk("br_pend2", 32'(redirect_pend), 32'h1);
      chk("br_pc2",   32'(pc_update),     32'h1);
      chk("br_load2", 32'(stage_load),    32'h11);
      step(); #1;
      chk("br_pend3",  32'(redirect_pend), 32'h0);
      chk("br_valid3", 32'(stage_valid),   32'h11);

      // WB flush with a full pipe and the fetch returning.
      steps(4); #1;
      chk("fl_full", 32'(stage_valid), 32'h1f);
      drive(1, 0, 0, 1, 1, 1); #1;
      chk("fl_pc", 32'(pc_update), 32'h1);
      step();
      drive(1, 0, 0, 1, 1, 0); #1;
      chk("fl_valid", 32'(stage_valid),   32'h01);
      chk("fl_pend",  32'(redirect_pend), 32'h0);
      chk("fl_cnt",   stall_cnt, 32'h1);

      // Flush and branch together while the fetch is pending.
      steps(4); #1;
      chk("fb_full", 32'(stage_valid), 32'h1f);
      drive(0, 1, 0, 1, 1, 1); #1;
      step();
      drive(0, 0, 0, 1, 1, 0); #1;
      chk("fb_valid", 32'(stage_valid),   32'h01);
      chk("fb_pend",  32'(redirect_pend), 32'h1);
      chk("fb_cnt",   stall_cnt, 32'h1);
      chk("fb_pc",    32'(pc_update),     32'h0);
      chk("fb_load",  32'(stage_load),    32'h00);

      // Asynchronous reset in the middle of a cycle.
      #2 resetn = 1'b0;
      #1;
      chk("ar_valid", 32'(stage_valid),   32'h0);
      chk("ar_load",  32'(stage_load),    32'h0);
      chk("ar_pc",    32'(pc_update),     32'h0);
      chk("ar_pend",  32'(redirect_pend), 32'h0);
      chk("ar_cnt",   stall_cnt, 32'h0);
      @(negedge clk);
      resetn = 1'b1;
      drive(1, 0, 0, 1, 1, 0);
      step(); #1;
      chk("ar_pc_back", 32'(pc_update), 32'h1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
